// File: rtl/pico_ex_pkg.sv
// Shared types and constants for the execute issue stage: ALU op codes,
// default widths, the buffered instruction record and the forward-match helper.
package pico_ex_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] ALU_NOP = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_RSV = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [1:0]        op;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic [REG_AW-1:0] rj_addr;
    logic [REG_AW-1:0] rk_addr;
    logic              b_is_imm;
  } ex_entry_t;

  // Register 0 is hard-wired, so a write to it never produces a bypass.
  function automatic logic fwd_match(input logic              valid,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] src);
    return valid && (rd != {REG_AW{1'b0}}) && (rd == src);
  endfunction

endpackage

// File: rtl/ex_issue_stage_if.sv
// Decode-side, writeback-bypass and ALU-side signals of the execute issue stage.
// master = surrounding pipeline, slave = the issue stage itself.
interface ex_issue_stage_if #(
  parameter int DATA_W = pico_ex_pkg::DATA_W,
  parameter int REG_AW = pico_ex_pkg::REG_AW
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_rj_data;
  logic [DATA_W-1:0] in_rk_data;
  logic [DATA_W-1:0] in_imm;
  logic              in_use_imm;
  logic [REG_AW-1:0] in_rj_addr;
  logic [REG_AW-1:0] in_rk_addr;
  logic [1:0]        in_alu_op;
  logic [REG_AW-1:0] in_rd;
  logic              in_rd_we;
  logic              flush;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [1:0]        operation;
  logic [REG_AW-1:0] out_rd;
  logic              out_rd_we;

  modport master (
    output in_valid, in_rj_data, in_rk_data, in_imm, in_use_imm, in_rj_addr,
           in_rk_addr, in_alu_op, in_rd, in_rd_we, flush, fwd_valid, fwd_rd,
           fwd_data, out_ready,
    input  in_ready, out_valid, operand_a, operand_b, operation, out_rd, out_rd_we
  );

  modport slave (
    input  in_valid, in_rj_data, in_rk_data, in_imm, in_use_imm, in_rj_addr,
           in_rk_addr, in_alu_op, in_rd, in_rd_we, flush, fwd_valid, fwd_rd,
           fwd_data, out_ready,
    output in_ready, out_valid, operand_a, operand_b, operation, out_rd, out_rd_we
  );

endinterface

// File: rtl/ex_operand_fwd.sv
// Combinational writeback bypass for one operand. Active only when the
// PICO_EX_FWD_EN macro is defined; otherwise the value passes through unchanged.
module ex_operand_fwd
  import pico_ex_pkg::*;
(
  input  logic [REG_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] value,
  input  logic              is_imm,
  input  logic              fwd_valid,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0] next_value
);

`ifdef PICO_EX_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  logic hit_s;

  // Replace a register-sourced operand with the matching writeback value
  always_comb begin
    hit_s = FWD_EN && !is_imm && fwd_match(fwd_valid, fwd_rd, src_addr);
    if (hit_s) begin
      next_value = fwd_data;
    end else begin
      next_value = value;
    end
  end

endmodule

// File: rtl/ex_issue_stage.sv
// Decode-to-execute issue stage: 2-entry skid buffer feeding the ALU, with
// immediate select and writeback bypass (bypass built only with PICO_EX_FWD_EN).
module ex_issue_stage #(
  parameter int DATA_W = pico_ex_pkg::DATA_W,
  parameter int REG_AW = pico_ex_pkg::REG_AW
) (
  input logic              clk,
  input logic              rst_n,
  ex_issue_stage_if.slave  bus
);
  import pico_ex_pkg::*;

  ex_entry_t head_r, skid_r;
  ex_entry_t head_nxt_s, skid_nxt_s;
  ex_entry_t in_entry_s, head_cur_s, skid_cur_s;
  logic      head_valid_r, skid_valid_r, in_ready_r;
  logic      head_valid_nxt_s, skid_valid_nxt_s;
  logic      accept_s, consume_s, head_free_s;

  logic [DATA_W-1:0] in_b_raw_s;
  logic [DATA_W-1:0] in_a_s, in_b_s;
  logic [DATA_W-1:0] head_a_s, head_b_s;
  logic [DATA_W-1:0] skid_a_s, skid_b_s;

  // Operand B source for the incoming instruction
  always_comb begin
    if (bus.in_use_imm) begin
      in_b_raw_s = bus.in_imm;
    end else begin
      in_b_raw_s = bus.in_rk_data;
    end
  end

  ex_operand_fwd u_fwd_in_a (
    .src_addr(bus.in_rj_addr), .value(bus.in_rj_data), .is_imm(1'b0),
    .fwd_valid(bus.fwd_valid), .fwd_rd(bus.fwd_rd), .fwd_data(bus.fwd_data),
    .next_value(in_a_s)
  );
  ex_operand_fwd u_fwd_in_b (
    .src_addr(bus.in_rk_addr), .value(in_b_raw_s), .is_imm(bus.in_use_imm),
    .fwd_valid(bus.fwd_valid), .fwd_rd(bus.fwd_rd), .fwd_data(bus.fwd_data),
    .next_value(in_b_s)
  );
  ex_operand_fwd u_fwd_head_a (
    .src_addr(head_r.rj_addr), .value(head_r.a), .is_imm(1'b0),
    .fwd_valid(bus.fwd_valid), .fwd_rd(bus.fwd_rd), .fwd_data(bus.fwd_data),
    .next_value(head_a_s)
  );
  ex_operand_fwd u_fwd_head_b (
    .src_addr(head_r.rk_addr), .value(head_r.b), .is_imm(head_r.b_is_imm),
    .fwd_valid(bus.fwd_valid), .fwd_rd(bus.fwd_rd), .fwd_data(bus.fwd_data),
    .next_value(head_b_s)
  );
  ex_operand_fwd u_fwd_skid_a (
    .src_addr(skid_r.rj_addr), .value(skid_r.a), .is_imm(1'b0),
    .fwd_valid(bus.fwd_valid), .fwd_rd(bus.fwd_rd), .fwd_data(bus.fwd_data),
    .next_value(skid_a_s)
  );
  ex_operand_fwd u_fwd_skid_b (
    .src_addr(skid_r.rk_addr), .value(skid_r.b), .is_imm(skid_r.b_is_imm),
    .fwd_valid(bus.fwd_valid), .fwd_rd(bus.fwd_rd), .fwd_data(bus.fwd_data),
    .next_value(skid_b_s)
  );

  // Assemble the captured instruction and the bypass-refreshed held entries
  always_comb begin
    in_entry_s          = '0;
    in_entry_s.a        = in_a_s;
    in_entry_s.b        = in_b_s;
    in_entry_s.op       = bus.in_alu_op;
    in_entry_s.rd       = bus.in_rd;
    in_entry_s.we       = bus.in_rd_we;
    in_entry_s.rj_addr  = bus.in_rj_addr;
    in_entry_s.rk_addr  = bus.in_rk_addr;
    in_entry_s.b_is_imm = bus.in_use_imm;
    head_cur_s          = head_r;
    head_cur_s.a        = head_a_s;
    head_cur_s.b        = head_b_s;
    skid_cur_s          = skid_r;
    skid_cur_s.a        = skid_a_s;
    skid_cur_s.b        = skid_b_s;
  end

  // Handshake and head/skid movement; flush overrides every move and accept
  always_comb begin
    accept_s         = bus.in_valid && in_ready_r && !bus.flush;
    consume_s        = head_valid_r && bus.out_ready;
    head_free_s      = !head_valid_r || consume_s;
    head_nxt_s       = head_cur_s;
    skid_nxt_s       = skid_cur_s;
    head_valid_nxt_s = head_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (bus.flush) begin
      head_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (head_free_s) begin
      if (skid_valid_r) begin
        head_nxt_s       = skid_cur_s;
        head_valid_nxt_s = 1'b1;
        skid_valid_nxt_s = 1'b0;
      end else if (accept_s) begin
        head_nxt_s       = in_entry_s;
        head_valid_nxt_s = 1'b1;
      end else begin
        head_valid_nxt_s = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_nxt_s       = in_entry_s;
        skid_valid_nxt_s = 1'b1;
      end else begin
        skid_valid_nxt_s = skid_valid_r;
      end
    end
    // Empty slots hold zeros so op/we toward the ALU read as NOP when idle
    head_nxt_s = head_valid_nxt_s ? head_nxt_s : '0;
    skid_nxt_s = skid_valid_nxt_s ? skid_nxt_s : '0;
  end

  // Entry storage, valid flags and the registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r       <= '0;
      skid_r       <= '0;
      head_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      head_r       <= head_nxt_s;
      skid_r       <= skid_nxt_s;
      head_valid_r <= head_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= !skid_valid_nxt_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = head_valid_r;
  assign bus.operand_a = head_r.a[DATA_W-1:0];
  assign bus.operand_b = head_r.b[DATA_W-1:0];
  assign bus.operation = head_r.op;
  assign bus.out_rd    = head_r.rd[REG_AW-1:0];
  assign bus.out_rd_we = head_r.we;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Scoreboard bench for ex_issue_stage: directed instructions push expected ALU
// inputs, a negedge monitor pops and compares on each consumed head entry.
module tb_ex_issue_stage;

`ifdef PICO_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  ex_issue_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  ex_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each consumed head entry against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got a=%h b=%h op=%b with nothing expected (t=%0t)",
                   bus.operand_a, bus.operand_b, bus.operation, $time);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_a",  bus.operand_a, mon_e.a);
          chk("sb_b",  bus.operand_b, mon_e.b);
          chk("sb_op", {30'd0, bus.operation}, {30'd0, mon_e.op});
          chk("sb_rd", {27'd0, bus.out_rd}, {27'd0, mon_e.rd});
          chk("sb_we", {31'd0, bus.out_rd_we}, {31'd0, mon_e.we});
        end
      end
      if (!bus.out_valid) begin
        chk("idle_op", {30'd0, bus.operation}, 32'd0);
        chk("idle_we", {31'd0, bus.out_rd_we}, 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [31:0] rj_d, input logic [31:0] rk_d,
                       input logic [31:0] imm, input logic use_imm,
                       input logic [4:0] rj_a, input logic [4:0] rk_a,
                       input logic [1:0] op, input logic [4:0] rd, input logic we);
    bus.in_rj_data = rj_d;
    bus.in_rk_data = rk_d;
    bus.in_imm     = imm;
    bus.in_use_imm = use_imm;
    bus.in_rj_addr = rj_a;
    bus.in_rk_addr = rk_a;
    bus.in_alu_op  = op;
    bus.in_rd      = rd;
    bus.in_rd_we   = we;
  endtask

  task automatic send(input logic [31:0] rj_d, input logic [31:0] rk_d,
                      input logic [31:0] imm, input logic use_imm,
                      input logic [4:0] rj_a, input logic [4:0] rk_a,
                      input logic [1:0] op, input logic [4:0] rd, input logic we,
                      input logic [31:0] exp_a, input logic [31:0] exp_b);
    int n;
    drive(rj_d, rk_d, imm, use_imm, rj_a, rk_a, op, rd, we);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for rd=%0d, required 1", rd);
    end else begin
      sb_q.push_back('{exp_a, exp_b, op, rd, we});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_a"},     bus.operand_a, 32'd0);
    chk({tag, "_b"},     bus.operand_b, 32'd0);
    chk({tag, "_op"},    {30'd0, bus.operation}, 32'd0);
    chk({tag, "_rd"},    {27'd0, bus.out_rd}, 32'd0);
    chk({tag, "_we"},    {31'd0, bus.out_rd_we}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.fwd_valid = 1'b0;
    bus.fwd_rd    = 5'd0;
    bus.fwd_data  = 32'd0;
    bus.out_ready = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0);

    // Reset state
    #12;
    chk_cleared("rst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(1);

    // Single op, one-cycle latency
    bus.out_ready = 1'b1;
    send(32'h10, 32'h20, 32'h0, 1'b0, 5'd1, 5'd2, 2'b01, 5'd7, 1'b1, 32'h10, 32'h20);
    bus.in_valid = 1'b0;
    chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lat_a", bus.operand_a, 32'h10);
    chk("lat_b", bus.operand_b, 32'h20);
    chk("lat_op", {30'd0, bus.operation}, 32'd1);
    cyc(1);
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_op", {30'd0, bus.operation}, 32'd0);

    // Immediate select
    send(32'h3, 32'h5, 32'hFFFF_FFF0, 1'b1, 5'd1, 5'd2, 2'b10, 5'd8, 1'b1, 32'h3, 32'hFFFF_FFF0);
    bus.in_valid = 1'b0;
    chk("imm_b", bus.operand_b, 32'hFFFF_FFF0);
    cyc(1);

    // Stall: two accepts fill head and skid, third held off
    bus.out_ready = 1'b0;
    send(32'hA1, 32'hA2, 32'h0, 1'b0, 5'd1, 5'd2, 2'b01, 5'd9, 1'b1, 32'hA1, 32'hA2);
    chk("skid_rdy1", {31'd0, bus.in_ready}, 32'd1);
    send(32'hB1, 32'hB2, 32'h0, 1'b0, 5'd1, 5'd2, 2'b10, 5'd10, 1'b1, 32'hB1, 32'hB2);
    chk("skid_rdy0", {31'd0, bus.in_ready}, 32'd0);
    drive(32'hC1, 32'hC2, 32'h0, 1'b0, 5'd1, 5'd2, 2'b01, 5'd11, 1'b0);
    bus.in_valid = 1'b1;
    cyc(2);
    chk("hold_rdy", {31'd0, bus.in_ready}, 32'd0);
    chk("hold_a", bus.operand_a, 32'hA1);
    bus.out_ready = 1'b1;
    send(32'hC1, 32'hC2, 32'h0, 1'b0, 5'd1, 5'd2, 2'b01, 5'd11, 1'b0, 32'hC1, 32'hC2);
    bus.in_valid = 1'b0;
    chk("drain_c_a", bus.operand_a, 32'hC1);
    cyc(2);

    // Bypass into stalled head; reg 0 and immediates are never replaced
    bus.out_ready = 1'b0;
    send(32'h1, 32'h2, 32'h0, 1'b0, 5'd3, 5'd4, 2'b01, 5'd12, 1'b1,
         FWD ? 32'hABCD : 32'h1, 32'h2);
    send(32'h77, 32'h99, 32'h3, 1'b1, 5'd0, 5'd3, 2'b10, 5'd13, 1'b0, 32'h77, 32'h3);
    bus.in_valid = 1'b0;
    chk("fwd_pre_a", bus.operand_a, 32'h1);
    bus.fwd_valid = 1'b1;
    bus.fwd_rd    = 5'd0;
    bus.fwd_data  = 32'h5555;
    cyc(1);
    chk("fwd_r0_a", bus.operand_a, 32'h1);
    bus.fwd_rd   = 5'd3;
    bus.fwd_data = 32'hABCD;
    cyc(1);
    chk("fwd_hit_a", bus.operand_a, FWD ? 32'hABCD : 32'h1);
    chk("fwd_hit_b", bus.operand_b, 32'h2);
    bus.fwd_valid = 1'b0;
    bus.out_ready = 1'b1;
    cyc(3);

    // Bypass at capture
    bus.fwd_valid = 1'b1;
    bus.fwd_rd    = 5'd5;
    bus.fwd_data  = 32'h1234;
    send(32'h55, 32'h66, 32'h0, 1'b0, 5'd5, 5'd5, 2'b01, 5'd14, 1'b1,
         FWD ? 32'h1234 : 32'h55, FWD ? 32'h1234 : 32'h66);
    bus.in_valid  = 1'b0;
    bus.fwd_valid = 1'b0;
    cyc(2);

    // Flush with full skid and a pending input
    bus.out_ready = 1'b0;
    send(32'hD1, 32'hD2, 32'h0, 1'b0, 5'd1, 5'd2, 2'b01, 5'd15, 1'b1, 32'hD1, 32'hD2);
    send(32'hE1, 32'hE2, 32'h0, 1'b0, 5'd1, 5'd2, 2'b10, 5'd16, 1'b1, 32'hE1, 32'hE2);
    drive(32'hF1, 32'hF2, 32'h0, 1'b0, 5'd1, 5'd2, 2'b01, 5'd17, 1'b1);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    sb_q.delete();
    cyc(1);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    cyc(3);

    // Flush beats an accept into an empty stage
    drive(32'h91, 32'h92, 32'h0, 1'b0, 5'd1, 5'd2, 2'b01, 5'd20, 1'b1);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    cyc(1);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_wins", {31'd0, bus.out_valid}, 32'd0);
    cyc(2);

    // Async reset mid-stall, away from the clock edge
    bus.out_ready = 1'b0;
    send(32'h61, 32'h62, 32'h0, 1'b0, 5'd1, 5'd2, 2'b01, 5'd18, 1'b1, 32'h61, 32'h62);
    send(32'h63, 32'h64, 32'h0, 1'b0, 5'd1, 5'd2, 2'b10, 5'd19, 1'b1, 32'h63, 32'h64);
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk_cleared("arst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(1);

    // Normal traffic resumes after reset
    bus.out_ready = 1'b1;
    send(32'h71, 32'h72, 32'h0, 1'b0, 5'd1, 5'd2, 2'b01, 5'd21, 1'b1, 32'h71, 32'h72);
    bus.in_valid = 1'b0;
    cyc(3);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
